// File: rtl/event_timestamp.sv
// event_timestamp: timestamps rising edges of an asynchronous event line
// with the local free-running count and queues them in a small
// first-word-fall-through FIFO.
//
// Ports:
//   clk       - single clock, all state on the rising edge
//   reset     - asynchronous active-low reset
//   count_in  - free-running count from the upstream counter (same domain)
//   event_in  - asynchronous event line
//   clear_ovf - single-cycle pulse clearing the sticky overflow flag
//   ts_ready  - consumer accepts the head entry
//   ts_data   - head-of-FIFO timestamp (don't-care while ts_valid=0)
//   ts_valid  - FIFO non-empty
//   level     - FIFO occupancy, 0..DEPTH
//   overflow  - sticky flag: an event was dropped because the FIFO was full
module event_timestamp #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             event_in,
  input  logic             clear_ovf,
  input  logic             ts_ready,
  output logic [WIDTH-1:0] ts_data,
  output logic             ts_valid,
  output logic [4:0]       level,
  output logic             overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = 5;

  // Synchronizer pair plus history flop for edge detection
  logic s1_q, s2_q, s3_q;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] level_after_pop;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic edge_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  assign edge_c = s2_q & ~s3_q;
  assign full_c = (level_q == LVL_W'(DEPTH));
  assign pop_c  = valid_q & ts_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign push_c = edge_c & (~full_c | pop_c);
  assign drop_c = edge_c & full_c & ~pop_c;

  // Event synchronizer and history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= event_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Next-state for pointers, occupancy, flags and the registered head
  always_comb begin
    wr_d            = wr_q;
    rd_d            = rd_q;
    level_d         = level_q;
    ovf_d           = ovf_q;
    data_d          = data_q;
    level_after_pop = level_q - LVL_W'(pop_c);

    if (push_c) wr_d = wr_q + PTR_W'(1);
    if (pop_c)  rd_d = rd_q + PTR_W'(1);

    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Set has priority over clear
    if (drop_c)         ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;

    // The new entry becomes the head only if nothing older survives the pop
    if (push_c && (level_after_pop == '0)) data_d = count_in;
    else if (level_d != '0)                data_d = mem_q[rd_d];

    valid_d = (level_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  // Storage needs no reset: occupancy and the head register gate visibility
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_q] <= count_in;
  end

  assign ts_data  = data_q;
  assign ts_valid = valid_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_event_timestamp.sv
// Directed bench for event_timestamp: a scoreboard queue holds the
// timestamps expected in the FIFO, filled when events are driven and
// drained when entries are popped.
module tb_event_timestamp;

  logic        clk;
  logic        reset;
  logic [15:0] count_in;
  logic        event_in;
  logic        clear_ovf;
  logic        ts_ready;
  logic [15:0] ts_data;
  logic        ts_valid;
  logic [4:0]  level;
  logic        overflow;

  int unsigned vectors;
  int unsigned miscompares;
  logic [15:0] sb [$];

  event_timestamp #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .event_in  (event_in),
    .clear_ovf (clear_ovf),
    .ts_ready  (ts_ready),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .level     (level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
    count_in = count_in + 16'd1;
  endtask

  task automatic pop_one(input string tag);
    logic [15:0] exp;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    exp = sb.pop_front();
    check({tag, "_valid"}, 32'(ts_valid), 32'd1);
    check({tag, "_data"}, 32'(ts_data), 32'(exp));
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
  endtask

  // Event high for two sampled edges, then low; push lands on the third edge
  task automatic fire(input bit drop, input bit clr_at_push, input bit pop_at_push);
    logic [15:0] exp;
    logic [15:0] head;
    exp = count_in + 16'd2;
    if (!drop) sb.push_back(exp);
    event_in = 1'b1;
    tick();
    tick();
    event_in = 1'b0;
    if (clr_at_push) clear_ovf = 1'b1;
    if (pop_at_push) begin
      head = sb.pop_front();
      check("pushpop_head", 32'(ts_data), 32'(head));
      ts_ready = 1'b1;
    end
    tick();
    clear_ovf = 1'b0;
    ts_ready  = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    logic [15:0] exp_rst;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    count_in    = 16'd0;
    event_in    = 1'b0;
    clear_ovf   = 1'b0;
    ts_ready    = 1'b0;

    // Reset state
    #12;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(ts_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(ts_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single event: count 5 at the first sampling edge -> timestamp 7
    repeat (5) tick();
    event_in = 1'b1;
    sb.push_back(16'h0007);
    tick();
    check("lat_e1_valid", 32'(ts_valid), 32'd0);
    tick();
    check("lat_e2_valid", 32'(ts_valid), 32'd0);
    tick();
    check("lat_e3_valid", 32'(ts_valid), 32'd1);
    check("lat_e3_data", 32'(ts_data), 32'h0007);
    check("lat_e3_level", 32'(level), 32'd1);
    event_in = 1'b0;
    tick();
    tick();
    check("single_level_hold", 32'(level), 32'd1);
    pop_one("single_pop");
    check("single_level0", 32'(level), 32'd0);
    check("single_valid0", 32'(ts_valid), 32'd0);

    // Ready while empty is ignored
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    check("empty_ready_level", 32'(level), 32'd0);
    check("empty_ready_valid", 32'(ts_valid), 32'd0);

    // Fill four, fifth is dropped
    for (int i = 0; i < 4; i++) fire(1'b0, 1'b0, 1'b0);
    check("fill_level4", 32'(level), 32'd4);
    check("fill_ovf0", 32'(overflow), 32'd0);
    fire(1'b1, 1'b0, 1'b0);
    check("drop_level4", 32'(level), 32'd4);
    check("drop_ovf1", 32'(overflow), 32'd1);
    check("drop_head", 32'(ts_data), 32'(sb[0]));

    // Clear alone, then a clear racing a drop: set wins
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr_alone_ovf0", 32'(overflow), 32'd0);
    fire(1'b1, 1'b1, 1'b0);
    check("clr_race_ovf1", 32'(overflow), 32'd1);
    check("clr_race_level", 32'(level), 32'd4);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr_after_ovf0", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop
    fire(1'b0, 1'b0, 1'b1);
    check("fullpp_level4", 32'(level), 32'd4);
    check("fullpp_ovf0", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) pop_one("drain");
    check("drain_level0", 32'(level), 32'd0);
    check("drain_valid0", 32'(ts_valid), 32'd0);

    // Count wrap: timestamps 0xFFFE then 0x0004
    count_in = 16'hFFFA;
    tick();
    tick();
    check("wrap_setup", 32'(count_in), 32'h0000FFFC);
    fire(1'b0, 1'b0, 1'b0);
    fire(1'b0, 1'b0, 1'b0);
    check("wrap_level2", 32'(level), 32'd2);
    check("wrap_head", 32'(ts_data), 32'h0000FFFE);
    pop_one("wrap_pop1");
    check("wrap_second", 32'(ts_data), 32'h00000004);
    pop_one("wrap_pop2");
    check("wrap_level0", 32'(level), 32'd0);

    // Build level 3 with overflow set, then reset between edges
    for (int i = 0; i < 4; i++) fire(1'b0, 1'b0, 1'b0);
    fire(1'b1, 1'b0, 1'b0);
    pop_one("pre_rst_pop");
    check("pre_rst_level3", 32'(level), 32'd3);
    check("pre_rst_ovf1", 32'(overflow), 32'd1);
    reset    = 1'b0;
    event_in = 1'b1;
    #2;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_valid", 32'(ts_valid), 32'd0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    sb.delete();
    @(negedge clk);
    reset   = 1'b1;
    exp_rst = count_in + 16'd2;
    sb.push_back(exp_rst);
    tick();
    check("rel_e1_valid", 32'(ts_valid), 32'd0);
    tick();
    check("rel_e2_valid", 32'(ts_valid), 32'd0);
    tick();
    check("rel_e3_valid", 32'(ts_valid), 32'd1);
    check("rel_e3_level", 32'(level), 32'd1);
    repeat (4) tick();
    check("rel_once_level", 32'(level), 32'd1);
    event_in = 1'b0;
    tick();
    tick();
    pop_one("rel_pop");
    check("rel_level0", 32'(level), 32'd0);
    check("rel_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/event_timestamp.md
EVENT_TIMESTAMP -- requirements
Module: event_timestamp

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, setting the width of the timestamp and count input.
REQ-002 The module SHALL have parameter DEPTH, default 4, setting the FIFO entry count (power of two, 2..16).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port count_in, input, WIDTH bits: free-running count value from the upstream counter, same clock domain.
REQ-006 The module SHALL have port event_in, input, 1 bit: asynchronous event line.
REQ-007 The module SHALL have port clear_ovf, input, 1 bit: single-cycle pulse that clears the overflow flag.
REQ-008 The module SHALL have port ts_ready, input, 1 bit: consumer accepts the head entry.
REQ-009 The module SHALL have port ts_data, output, WIDTH bits: the head-of-FIFO timestamp.
REQ-010 The module SHALL have port ts_valid, output, 1 bit: the FIFO is non-empty.
REQ-011 The module SHALL have port level, output, 5 bits: current FIFO occupancy, 0..DEPTH.
REQ-012 The module SHALL have port overflow, output, 1 bit: sticky flag indicating an event was dropped.

Function
REQ-013 event_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-014 A rising edge SHALL be detected when s2=1 and s3=0.
REQ-015 Each detected edge SHALL yield exactly one push attempt.
REQ-016 On a push, the value of count_in sampled at the same clk edge SHALL be written as the timestamp.
REQ-017 Latency SHALL be as follows: event_in high at clk edge k results in a push at edge k+2, with ts_valid high after edge k+2 if the FIFO was empty.
REQ-018 count_in SHALL be stored verbatim, with no interpretation of wrap-around or upstream reset.
REQ-019 The FIFO SHALL be first-word-fall-through: ts_data equals the oldest entry whenever ts_valid=1.
REQ-020 ts_data SHALL be a don't-care when ts_valid=0.
REQ-021 A pop SHALL occur on a clk edge where ts_valid=1 and ts_ready=1.
REQ-022 ts_ready while empty SHALL be ignored.
REQ-023 On simultaneous push and pop with level=DEPTH, both SHALL be accepted and level SHALL remain DEPTH.
REQ-024 On simultaneous push and pop with 0<level<DEPTH, both SHALL be accepted and level SHALL be unchanged.
REQ-025 A push with level=DEPTH and no pop SHALL be dropped: FIFO contents unchanged and overflow set to 1.
REQ-026 overflow SHALL remain 1 until the first clk edge with clear_ovf=1.
REQ-027 When clear_ovf and a drop occur on the same edge, overflow SHALL be 1 (set wins).
REQ-028 level SHALL update on the same edge as the push or pop.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 An event pulse shorter than one clk period MAY be missed.
REQ-031 Each event held at least 2 clk periods low and 2 high SHALL be captured exactly once.

Reset
REQ-032 While reset=0, s1, s2, s3, pointers, level, ts_valid, and overflow SHALL all be 0, and ts_data SHALL be 0.
REQ-033 Assertion of reset SHALL take effect immediately, without a clock edge.
REQ-034 Assertion of reset SHALL discard any stored entries.
REQ-035 If event_in is high when reset releases, this SHALL count as a rising edge, with the push on the 3rd clk edge after release.
REQ-036 Reset assertion mid-operation SHALL lose all pending entries, and no partial push SHALL occur.

Verification
REQ-037 Single event: clk period 10, count_in increments by 1 per edge from 0 after reset release; event_in rises before the edge where count_in=0x0005 -> ts_valid rises 2 edges later with ts_data=0x0007 and level=1; one pop -> level=0 and ts_valid=0.
REQ-038 Fill and overflow: with ts_ready=0, 5 events spaced 6 cycles apart -> level=4, overflow=1 after the 5th push attempt, and the 4 stored timestamps are the first four in order.
REQ-039 Full with simultaneous push/pop: at level=4, ts_ready=1 on the push edge -> level stays 4, overflow stays 0, and the oldest entry is replaced at the tail by the new one.
REQ-040 Clear race: clear_ovf pulsed on the same edge as a drop -> overflow=1; clear_ovf pulsed alone afterwards -> overflow=0.
REQ-041 Wrap-around: count_in passes 0xFFFF to 0x0000; events at 0xFFFE and 0x0004 -> timestamps 0xFFFE then 0x0004, popped in order.
REQ-042 Reset mid-operation: with level=3 and overflow=1, reset pulsed low between edges -> level=0, ts_valid=0, and overflow=0 immediately; with event_in held high through release -> exactly one timestamp, pushed at the 3rd edge after release.
